seq_detector_param: RTL
=======================

# seq_detector_param

Parameterised Mealy serial-pattern detector, the generalised successor to the fixed 110 non-overlapping detector. It has a runtime-loadable pattern of PAT_W bits, overlap or non-overlap mode selectable per cycle, a qualified input stream, and an optional saturating match counter. The block sits on a single-bit serial data path and flags each pattern occurrence combinationally in the cycle the final bit arrives.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..32.
- PAT_RST, 3'b110: pattern in effect after reset. Bit PAT_W-1 is the first bit received.
- CNT_W, 8: match counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din_valid  in  1  din is accepted only in cycles where this is high.
- din  in  1  serial data bit.
- pat_load  in  1  loads pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern; MSB is compared against the oldest bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled in the match cycle.
- dout1  out  1  Mealy match flag, combinational.
- state  out  $clog2(PAT_W)  fill count: valid history bits, 0..PAT_W-1.
- match_cnt  out  CNT_W  saturating number of matches.

## Operation
- Registers:
  - hist[PAT_W-2:0]: the last accepted bits, with the newest at bit 0.
  - fill: the current fill count.
  - pat: the active pattern.
  - match_cnt: the match counter.
- Match condition: dout1 = din_valid & ~reset & ~pat_load & (fill == PAT_W-1) & ({hist, din} == pat).
- Accepted bit (din_valid=1, pat_load=0, reset=0), in order:
  - hist shifts left and takes din at bit 0.
  - No match: fill = min(fill+1, PAT_W-1).
  - Match with overlap=1: fill stays PAT_W-1 and hist keeps the shifted value.
  - Match with overlap=0: fill goes to 0 and hist clears to 0, so bits from this match are never reused.
- din_valid=0: hist, fill and match_cnt hold, and dout1 is 0.
- pat_load=1 takes priority over din_valid:
  - pat takes pat_in; fill, hist and match_cnt clear to 0.
  - din in that cycle is discarded and dout1 is 0.
- Reset is the highest priority. It sets pat=PAT_RST and clears hist, fill and match_cnt, and dout1 is 0.

## Timing
- Reset values:
  - dout1=0
  - state=0
  - match_cnt=0
  - pat=PAT_RST
- Match latency: 0 cycles. dout1 rises combinationally in the cycle the last pattern bit is presented with din_valid.
- Reset is synchronous: outputs take their reset values after the first rising edge with reset=1. dout1 is additionally forced low combinationally while reset is high.
- Minimum spacing between non-overlapping matches is PAT_W accepted bits.
- Overlap spacing is bounded only by the pattern's self-overlap. For example, pattern 11 on a stream of all 1s matches on every accepted bit after the first.
- match_cnt updates one edge after dout1 and saturates at 2^CNT_W-1; it never wraps.
- Reset or pat_load in the middle of a partial sequence discards all partial progress. There is no match in that cycle, and the first possible match is PAT_W accepted bits later.

## Configuration
- SEQ_DET_MATCH_CNT_EN defined: the match counter is built as described above.
- SEQ_DET_MATCH_CNT_EN undefined: no counter flops are built. match_cnt is tied to 0 and the port list is unchanged.

## Structure
- Package seq_det_pkg holds:
  - Function fill_w(PAT_W) returning $clog2(PAT_W).
  - Constant DEFAULT_PAT_110.
  - Typedef mode_e {NON_OVERLAP=0, OVERLAP=1}.
- One sub-module, sat_counter:
  - Parameter CNT_W.
  - Ports clk, reset, clr, inc, count.
  - Instantiated only under SEQ_DET_MATCH_CNT_EN.

## Test plan
- Reset: hold reset for 3 cycles with din=1 and din_valid=1 → dout1=0, state=0, match_cnt=0 throughout and after release.
- Default pattern 110, overlap=0: stream 1,1,0,1,1,0 → dout1=1 on the 3rd and 6th bits, state=0 after each match, match_cnt=2.
- pat_load 3'b101: stream 1,0,1,0,1 → overlap=1 gives matches on bits 3 and 5 (match_cnt=2); overlap=0 gives a match on bit 3 only (match_cnt=1).
- Gaps: 1,(gap),1,(gap),(gap),0 with din_valid low in the gaps → a single match on the final 0, and state holds through the gaps.
- pat_load mid-stream: after 1,1, load 3'b011 with din=0 in the load cycle → no match and state=0; then 0,1,1 → match on the last 1.
- Counter saturation with CNT_W=2 and pattern 11, overlap=1: stream of 1s for 7 bits → 6 matches, match_cnt=3 held. Without SEQ_DET_MATCH_CNT_EN, match_cnt=0 always.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// seq_det_pkg: shared definitions for the parameterised serial pattern detector.
//   fill_w()         width of the fill-count (state) output for a pattern length
//   DEFAULT_PAT_110  legacy pattern, used as the reset pattern by default
//   mode_e           overlap / non-overlap detection mode
package seq_det_pkg;

  localparam logic [2:0] DEFAULT_PAT_110 = 3'b110;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial data / pattern-control bundle of the detector.
//   master (stimulus side): drives din_valid, din, pat_load, pat_in, overlap;
//                           observes dout1, state, match_cnt
//   slave  (detector side): the mirror image
// Handshake: din is consumed in every cycle where din_valid=1 and pat_load=0;
// there is no back-pressure, so the detector is always ready. pat_load wins
// over din_valid and discards that cycle's din.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  localparam int FW = fill_w(PAT_W);

  logic             din_valid;
  logic             din;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             dout1;
  logic [FW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din_valid, din, pat_load, pat_in, overlap,
    input  dout1, state, match_cnt
  );

  modport slave (
    input  din_valid, din, pat_load, pat_in, overlap,
    output dout1, state, match_cnt
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: up-counter that stops at its all-ones value instead of wrapping.
//   clk, reset  clock and synchronous active-high reset
//   clr         synchronous clear (lower priority than reset, above inc)
//   inc         count one event
//   count       current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy detector for a runtime-loadable PAT_W-bit pattern
// on a qualified serial stream, with overlap mode chosen per match cycle.
//   clk, reset  clock and synchronous active-high reset
//   bus         seq_detector_param_if.slave:
//                 din_valid/din   serial input, qualified
//                 pat_load/pat_in load a new pattern (MSB = oldest bit)
//                 overlap         1 = overlapping, 0 = non-overlapping
//                 dout1           combinational match flag
//                 state           fill count of the history, 0..PAT_W-1
//                 match_cnt       saturating match count
// Build option: define SEQ_DET_MATCH_CNT_EN to build the match counter;
// otherwise match_cnt is tied to zero.
// The interface instance must carry the same PAT_W and CNT_W as this module.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEFAULT_PAT_110),
  parameter int               CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int            FW   = fill_w(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  localparam logic [FW-1:0] ONE  = 1;

  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [PAT_W-1:0] pat_q;

  logic [PAT_W-1:0] window;
  logic             accept;
  logic             match;
  mode_e            mode;

  // The history plus the bit arriving now forms the candidate; its low
  // PAT_W-1 bits are also the shifted history.
  assign window = {hist_q, bus.din};
  assign accept = bus.din_valid & ~bus.pat_load & ~reset;
  assign match  = accept & (fill_q == FULL) & (window == pat_q);
  assign mode   = mode_e'(bus.overlap);

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bus.pat_load) begin
      pat_q  <= bus.pat_in;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bus.din_valid) begin
      if (match && (mode == NON_OVERLAP)) begin
        // Start over so no bit of this match is reused.
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= window[PAT_W-2:0];
        // Saturating increment also covers an overlapping match at FULL.
        fill_q <= (fill_q == FULL) ? FULL : (fill_q + ONE);
      end
    end
  end

  assign bus.dout1 = match;
  assign bus.state = fill_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.pat_load),
    .inc   (match),
    .count (bus.match_cnt)
  );
`else
  assign bus.match_cnt = '0;
`endif
endmodule
